// File: rtl/mult_seq_ctrl.sv
// Moore sequencer for a shift-add multiplier datapath: issues load/add/shift
// strobes, counts processed multiplier bits and reports busy/done.
module mult_seq_ctrl #(
  parameter int unsigned N  = 8,
  parameter int unsigned CW = 4
) (
  input  logic          C,
  input  logic          R,
  input  logic          start,
  input  logic          q0,
  input  logic          abort,
  output logic          ld,
  output logic          add,
  output logic          shf,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] cnt
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    TEST  = 3'd2,
    ADD   = 3'd3,
    SHIFT = 3'd4,
    DONE  = 3'd5
  } state_e;

  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // An aborted operation leaves cnt untouched, including in LOAD and SHIFT.
  always_comb begin
    state_d = IDLE;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE:  state_d = (start && !abort) ? LOAD : IDLE;
      LOAD: begin
        if (!abort) begin
          cnt_d   = '0;
          state_d = TEST;
        end
      end
      TEST:  if (!abort) state_d = q0 ? ADD : SHIFT;
      ADD:   if (!abort) state_d = SHIFT;
      SHIFT: begin
        if (!abort) begin
          cnt_d   = cnt_q + CW'(1);
          state_d = (cnt_q == LAST) ? DONE : TEST;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge C or posedge R) begin
    if (R) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs depend on the state register alone; unused encodings decode to all-zero.
  always_comb begin
    ld   = 1'b0;
    add  = 1'b0;
    shf  = 1'b0;
    done = 1'b0;
    busy = 1'b0;
    case (state_q)
      LOAD:  begin ld   = 1'b1; busy = 1'b1; end
      TEST:  begin              busy = 1'b1; end
      ADD:   begin add  = 1'b1; busy = 1'b1; end
      SHIFT: begin shf  = 1'b1; busy = 1'b1; end
      DONE:  begin done = 1'b1; busy = 1'b1; end
      default: ;
    endcase
  end

  assign cnt = cnt_q;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Scoreboard bench for mult_seq_ctrl: an N=4 and an N=1 instance, each driven
// by a small multiplier shift-register model that feeds q0.
module tb_mult_seq_ctrl;

  localparam logic [1:0] K_LD = 2'd0, K_ADD = 2'd1, K_SHF = 2'd2, K_DONE = 2'd3;

  typedef struct packed {
    logic [1:0]  kind;
    int unsigned cyc;
    logic [3:0]  cnt;
  } ev_t;

  logic C = 1'b0;
  logic R = 1'b1;

  logic       a_start = 1'b0, a_abort = 1'b0, a_q0;
  logic       a_ld, a_add, a_shf, a_busy, a_done;
  logic [3:0] a_cnt;
  logic       b_start = 1'b0, b_abort = 1'b0, b_q0;
  logic       b_ld, b_add, b_shf, b_busy, b_done;
  logic [3:0] b_cnt;

  logic [7:0] a_m = '0, a_opnd = '0, b_m = '0, b_opnd = '0;

  ev_t         qa[$];
  ev_t         qb[$];
  int unsigned cyc = 0;
  int          n_vec = 0;
  int          n_err = 0;

  mult_seq_ctrl #(.N(4), .CW(4)) u_a (
    .C(C), .R(R), .start(a_start), .q0(a_q0), .abort(a_abort),
    .ld(a_ld), .add(a_add), .shf(a_shf), .busy(a_busy), .done(a_done), .cnt(a_cnt)
  );

  mult_seq_ctrl #(.N(1), .CW(4)) u_b (
    .C(C), .R(R), .start(b_start), .q0(b_q0), .abort(b_abort),
    .ld(b_ld), .add(b_add), .shf(b_shf), .busy(b_busy), .done(b_done), .cnt(b_cnt)
  );

  always #5 C = ~C;
  always @(posedge C) cyc <= cyc + 1;

  // Multiplier register of the datapath: loads on ld, shifts right on shf.
  assign a_q0 = a_m[0];
  assign b_q0 = b_m[0];
  always @(posedge C) begin
    if (a_ld) a_m <= a_opnd; else if (a_shf) a_m <= a_m >> 1;
    if (b_ld) b_m <= b_opnd; else if (b_shf) b_m <= b_m >> 1;
  end

  function automatic string kname(input logic [1:0] k);
    case (k)
      K_LD:    return "ld";
      K_ADD:   return "add";
      K_SHF:   return "shf";
      default: return "done";
    endcase
  endfunction

  function automatic int unsigned qsize(input int d);
    return (d == 0) ? qa.size() : qb.size();
  endfunction

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic exp_ev(input int d, input logic [1:0] k, input int unsigned c, input logic [3:0] n);
    ev_t e;
    e.kind = k; e.cyc = c; e.cnt = n;
    if (d == 0) qa.push_back(e); else qb.push_back(e);
  endtask

  task automatic obs(input int d, input logic [1:0] k, input logic [3:0] n);
    ev_t e;
    n_vec++;
    if (qsize(d) == 0) begin
      n_err++;
      $display("FAIL dut%0d strobe: got %s cnt=%0d at cycle %0d, expected no strobe", d, kname(k), n, cyc);
    end else begin
      e = (d == 0) ? qa.pop_front() : qb.pop_front();
      if (e.kind != k || e.cyc != cyc || e.cnt != n) begin
        n_err++;
        $display("FAIL dut%0d strobe: got %s cnt=%0d at cycle %0d, expected %s cnt=%0d at cycle %0d",
                 d, kname(k), n, cyc, kname(e.kind), e.cnt, e.cyc);
      end
    end
  endtask

  always @(negedge C) begin
    if (a_ld)   obs(0, K_LD,   a_cnt);
    if (a_add)  obs(0, K_ADD,  a_cnt);
    if (a_shf)  obs(0, K_SHF,  a_cnt);
    if (a_done) obs(0, K_DONE, a_cnt);
    if (b_ld)   obs(1, K_LD,   b_cnt);
    if (b_add)  obs(1, K_ADD,  b_cnt);
    if (b_shf)  obs(1, K_SHF,  b_cnt);
    if (b_done) obs(1, K_DONE, b_cnt);
  end

  task automatic step();
    @(posedge C);
    #1;
  endtask

  task automatic wait_drain(input int d, input int unsigned lim);
    for (int unsigned i = 0; i < lim; i++) begin
      if (qsize(d) == 0) break;
      step();
    end
    n_vec++;
    if (qsize(d) != 0) begin
      n_err++;
      $display("FAIL dut%0d drain: got %0d pending strobes after %0d cycles, expected 0", d, qsize(d), lim);
      if (d == 0) qa.delete(); else qb.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion by time limit, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned b;
    #2;
    chk("rst_ld",   a_ld,   0);
    chk("rst_add",  a_add,  0);
    chk("rst_shf",  a_shf,  0);
    chk("rst_busy", a_busy, 0);
    chk("rst_done", a_done, 0);
    chk("rst_cnt",  a_cnt,  0);
    chk("rst_b_busy", b_busy, 0);
    step(); step();
    R = 1'b0;
    step(); step();
    chk("idle_busy", a_busy, 0);

    // q0 sequence 1,1,0,1 (multiplier 4'b1011)
    a_opnd = 8'h0B; b = cyc; a_start = 1'b1;
    exp_ev(0, K_LD, b+1, 0);  exp_ev(0, K_ADD, b+3, 0);  exp_ev(0, K_SHF, b+4, 0);
    exp_ev(0, K_ADD, b+6, 1); exp_ev(0, K_SHF, b+7, 1);  exp_ev(0, K_SHF, b+9, 2);
    exp_ev(0, K_ADD, b+11, 3); exp_ev(0, K_SHF, b+12, 3); exp_ev(0, K_DONE, b+13, 4);
    step(); a_start = 1'b0;
    wait_drain(0, 20);
    step();
    chk("t2_cnt_idle", a_cnt, 4);
    chk("t2_busy_idle", a_busy, 0);

    // q0 always 0; cnt holds 4 through IDLE into LOAD
    a_opnd = 8'h00; b = cyc; a_start = 1'b1;
    exp_ev(0, K_LD, b+1, 4);  exp_ev(0, K_SHF, b+3, 0); exp_ev(0, K_SHF, b+5, 1);
    exp_ev(0, K_SHF, b+7, 2); exp_ev(0, K_SHF, b+9, 3); exp_ev(0, K_DONE, b+10, 4);
    step(); a_start = 1'b0;
    for (int unsigned j = 1; j <= 11; j++) begin
      chk($sformatf("t3_busy_c%0d", j), a_busy, (j <= 10) ? 1 : 0);
      step();
    end
    wait_drain(0, 5);

    // start held high: back-to-back with one IDLE cycle; toggling start mid-op is ignored
    a_opnd = 8'h00; b = cyc; a_start = 1'b1;
    exp_ev(0, K_LD, b+1, 4);  exp_ev(0, K_SHF, b+3, 0);  exp_ev(0, K_SHF, b+5, 1);
    exp_ev(0, K_SHF, b+7, 2); exp_ev(0, K_SHF, b+9, 3);  exp_ev(0, K_DONE, b+10, 4);
    exp_ev(0, K_LD, b+12, 4); exp_ev(0, K_SHF, b+14, 0); exp_ev(0, K_SHF, b+16, 1);
    exp_ev(0, K_SHF, b+18, 2); exp_ev(0, K_SHF, b+20, 3); exp_ev(0, K_DONE, b+21, 4);
    for (int unsigned j = 1; j <= 21; j++) begin
      step();
      if (j == 11) chk("t4_idle_gap_busy", a_busy, 0);
      if (j == 12) chk("t4_reload_ld", a_ld, 1);
      a_start = (j < 12) ? 1'b1 : (j >= 20) ? 1'b0 : logic'(j % 2);
    end
    wait_drain(0, 5);
    step();

    // abort during the first ADD
    a_opnd = 8'h0B; b = cyc; a_start = 1'b1;
    exp_ev(0, K_LD, b+1, 4); exp_ev(0, K_ADD, b+3, 0);
    for (int unsigned j = 1; j <= 3; j++) begin
      step(); a_start = 1'b0;
      if (j == 3) a_abort = 1'b1;
    end
    step(); a_abort = 1'b0;
    chk("t5_abort_add_busy", a_busy, 0);
    chk("t5_abort_add_cnt",  a_cnt,  0);
    step();
    chk("t5_abort_add_busy2", a_busy, 0);

    // abort in the second SHIFT: cnt stays 1 instead of advancing
    a_opnd = 8'h00; b = cyc; a_start = 1'b1;
    exp_ev(0, K_LD, b+1, 0); exp_ev(0, K_SHF, b+3, 0); exp_ev(0, K_SHF, b+5, 1);
    for (int unsigned j = 1; j <= 5; j++) begin
      step(); a_start = 1'b0;
      if (j == 5) a_abort = 1'b1;
    end
    step(); a_abort = 1'b0;
    chk("t5_abort_shf_busy", a_busy, 0);
    chk("t5_abort_shf_cnt",  a_cnt,  1);
    step(); step();
    chk("t5_abort_shf_cnt_hold", a_cnt, 1);

    // start and abort together in IDLE
    a_start = 1'b1; a_abort = 1'b1;
    for (int unsigned j = 0; j < 3; j++) begin
      step();
      chk($sformatf("t5_start_abort_busy%0d", j), a_busy, 0);
    end
    a_start = 1'b0; a_abort = 1'b0;
    step();

    // asynchronous reset in the middle of the second ADD (cnt=1)
    a_opnd = 8'h0B; b = cyc; a_start = 1'b1;
    exp_ev(0, K_LD, b+1, 1); exp_ev(0, K_ADD, b+3, 0); exp_ev(0, K_SHF, b+4, 0);
    for (int unsigned j = 1; j <= 6; j++) begin
      step(); a_start = 1'b0;
    end
    chk("t1_pre_add", a_add, 1);
    chk("t1_pre_cnt", a_cnt, 1);
    #1 R = 1'b1;
    #1;
    chk("t1_rst_ld",   a_ld,   0);
    chk("t1_rst_add",  a_add,  0);
    chk("t1_rst_shf",  a_shf,  0);
    chk("t1_rst_busy", a_busy, 0);
    chk("t1_rst_done", a_done, 0);
    chk("t1_rst_cnt",  a_cnt,  0);
    step(); step();
    R = 1'b0;
    for (int unsigned j = 0; j < 4; j++) begin
      step();
      chk($sformatf("t1_post_busy%0d", j), a_busy, 0);
    end
    chk("t1_post_cnt", a_cnt, 0);
    chk("t1_queue_empty", qsize(0), 0);

    // N=1 instance
    b_opnd = 8'h00; b = cyc; b_start = 1'b1;
    exp_ev(1, K_LD, b+1, 0); exp_ev(1, K_SHF, b+3, 0); exp_ev(1, K_DONE, b+4, 1);
    step(); b_start = 1'b0;
    wait_drain(1, 10);
    step();
    chk("t6_q0_0_cnt", b_cnt, 1);

    b_opnd = 8'h01; b = cyc; b_start = 1'b1;
    exp_ev(1, K_LD, b+1, 1); exp_ev(1, K_ADD, b+3, 0);
    exp_ev(1, K_SHF, b+4, 0); exp_ev(1, K_DONE, b+5, 1);
    step(); b_start = 1'b0;
    wait_drain(1, 10);
    step();
    chk("t6_q0_1_cnt",  b_cnt,  1);
    chk("t6_q0_1_busy", b_busy, 0);
    step(); step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mult_seq_ctrl.md
Name: mult_seq_ctrl

Overview:
Moore FSM controller that sequences a shift-add multiplier datapath built from the team's standard gate and flip-flop cells. It issues load, add and shift strobes and counts multiplier bits. It samples the multiplier LSB from the datapath and signals busy and done to the surrounding system. It contains no arithmetic datapath of its own.

Parameters:
N, 8, operand width (number of multiplier bits processed); legal range 1..15.
CW, 4, width of bit counter cnt; must satisfy 2^CW > N.

Ports:
C  input  1  clock; all state changes on rising edge.
R  input  1  reset, asynchronous, active-high.
start  input  1  request to begin a multiplication; sampled only in IDLE.
q0  input  1  current multiplier LSB from datapath; sampled only in TEST.
abort  input  1  synchronous cancel of an operation in progress.
ld  output  1  one-cycle strobe: load operands, clear accumulator.
add  output  1  one-cycle strobe: accumulator += multiplicand.
shf  output  1  one-cycle strobe: shift accumulator/multiplier right by one.
busy  output  1  high in every state except IDLE.
done  output  1  one-cycle completion pulse.
cnt  output  CW  number of bits processed so far.

Behaviour:
- Reset: R=1 forces state IDLE and cnt=0 immediately, without waiting for a clock edge. While R is high, all outputs are 0.
- Outputs are decoded from the state register only (Moore). There is no combinational path from start, q0 or abort to any output.
- States and transitions, evaluated on each rising edge of C:
  - IDLE: start=1 and abort=0 -> LOAD; otherwise stay in IDLE.
  - LOAD: ld=1; cnt<=0 -> TEST.
  - TEST: no strobes; q0=1 -> ADD; q0=0 -> SHIFT.
  - ADD: add=1 -> SHIFT.
  - SHIFT: shf=1; cnt<=cnt+1. If cnt==N-1 -> DONE, else -> TEST.
  - DONE: done=1 -> IDLE.
- busy=1 in LOAD, TEST, ADD, SHIFT and DONE.
- Latency: if start is sampled at edge 0, ld is high in cycle 1. done is high in cycle 2N+p+2, where p is the number of q0=1 samples taken in TEST.
- cnt reaches N on entry to DONE. It holds that value through DONE and IDLE until the next LOAD. It never wraps.
- start is ignored while busy, including in DONE. If start is held high, the FSM returns to IDLE for exactly one cycle and then goes to LOAD (back-to-back operation).
- abort=1 in any busy state except DONE: next state is IDLE, no done pulse, cnt holds its current value.
- abort in DONE: done still completes and the FSM returns to IDLE as normal.
- abort=1 and start=1 together in IDLE: abort wins and the FSM stays in IDLE.
- q0 is don't-care outside TEST.
- Any unused state encoding -> IDLE on the next edge, with all strobes 0 in that cycle.
- R asserted mid-operation: immediate return to IDLE with cnt=0. No done pulse is produced. Operation resumes only after R falls and a new start is sampled.

Test Plan:
1. N=4. Assert R in the middle of an ADD state -> ld/add/shf/busy/done and cnt all go to 0 without a clock edge. After R falls, the FSM stays in IDLE until start is asserted.
2. N=4. q0 sequence 1,1,0,1 and a single-cycle start at edge 0 -> ld in cycle 1; add pulses in cycles 3, 6 and 11; shf pulses in cycles 4, 7, 9 and 12; done in cycle 13; cnt=4 afterwards.
3. N=4. q0 held at 0 -> add is never asserted; shf pulses in cycles 3, 5, 7 and 9; done in cycle 10; busy high in cycles 1 through 10.
4. N=4, q0=0, start held high continuously -> done in cycle 10, IDLE (busy=0) in cycle 11, ld again in cycle 12. Extra start pulses mid-operation cause no change.
5. N=4. Assert abort during the first ADD -> IDLE next cycle with no done pulse and cnt holding its value. Separately, start=1 with abort=1 in IDLE -> busy stays 0.
6. N=1 instance -> done in cycle 4 with q0=0 and in cycle 5 with q0=1; cnt=1 after completion.
